// File: rtl/reaction_stats.sv
// Per-session reaction-time statistics (last, best, running average, trial count)
// with a sequential shift-and-add-3 binary-to-BCD converter for the display.
module reaction_stats #(
    parameter int W      = 20,
    parameter int HIST   = 4,
    parameter int MAX_MS = 99999
) (
    input  logic         ADC_CLK_10,
    input  logic         reset,
    input  logic         clear_stats,
    input  logic         result_valid,
    input  logic [W-1:0] result_ms,
    input  logic [1:0]   sel,
    output logic [19:0]  bcd_out,
    output logic         bcd_valid,
    output logic         busy,
    output logic [W-1:0] best_ms,
    output logic [7:0]   trials,
    output logic         new_best
);

    localparam int LG = $clog2(HIST);
    localparam int SW = W + LG;
    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MAX_V = W'(MAX_MS);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    logic [W-1:0]  last_q;
    logic [W-1:0]  best_q;
    logic [W-1:0]  hist_q [HIST];
    logic [SW-1:0] sum_q;
    logic [7:0]    trials_q;
    logic          new_best_q;

    logic [W-1:0]  val_clamped;
    logic [SW-1:0] sum_d;
    logic [W-1:0]  avg;
    logic [W-1:0]  sel_value;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  bin_q, bin_d;
    logic [19:0]   scr_q, scr_d, scr_adj;
    logic          pending_q;
    logic [1:0]    sel_q;
    logic [19:0]   bcd_out_q;
    logic          bcd_valid_q;
    logic          busy_q;
    logic          trig;

    assign val_clamped = (result_ms > MAX_V) ? MAX_V : result_ms;
    assign sum_d       = sum_q + SW'(val_clamped) - SW'(hist_q[HIST-1]);
    assign trig        = (sel != sel_q) | clear_stats | result_valid;

    always_comb begin
        avg = last_q;
        if (trials_q >= 8'(HIST)) begin
            avg = sum_q[LG +: W];
        end
    end

    always_comb begin
        sel_value = '0;
        case (sel)
            2'd0:    sel_value = last_q;
            2'd1:    sel_value = best_q;
            2'd2:    sel_value = avg;
            default: sel_value = W'(trials_q);
        endcase
    end

    // Double-dabble step: correct every digit >= 5, then shift the whole
    // {bcd, binary} pair left by one.
    always_comb begin
        scr_adj = scr_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        {scr_d, bin_d} = {scr_adj, bin_q} << 1;
    end

    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            last_q     <= '0;
            best_q     <= MAX_V;
            sum_q      <= '0;
            trials_q   <= '0;
            new_best_q <= 1'b0;
            for (int unsigned i = 0; i < HIST; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            new_best_q <= 1'b0;
            if (clear_stats) begin
                last_q   <= '0;
                best_q   <= MAX_V;
                sum_q    <= '0;
                trials_q <= '0;
                for (int unsigned i = 0; i < HIST; i++) begin
                    hist_q[i] <= '0;
                end
            end else if (result_valid) begin
                last_q    <= val_clamped;
                sum_q     <= sum_d;
                hist_q[0] <= val_clamped;
                for (int unsigned i = 1; i < HIST; i++) begin
                    hist_q[i] <= hist_q[i-1];
                end
                if (trials_q != 8'hFF) begin
                    trials_q <= trials_q + 8'd1;
                end
                if (val_clamped < best_q) begin
                    best_q     <= val_clamped;
                    new_best_q <= 1'b1;
                end
            end
        end
    end

    // bcd_out/busy/bcd_valid are loaded on the edge entering DONE so they are
    // already visible during the DONE cycle; a trigger arriving while busy
    // (including on that final edge) is folded into pending for one rerun.
    always_ff @(posedge ADC_CLK_10 or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bin_q       <= '0;
            scr_q       <= '0;
            pending_q   <= 1'b0;
            sel_q       <= '0;
            bcd_out_q   <= '0;
            bcd_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            sel_q <= sel;
            case (state_q)
                IDLE: begin
                    if (trig) begin
                        state_q     <= LOAD;
                        bcd_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    bin_q   <= sel_value;
                    scr_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= SHIFT;
                    if (trig) begin
                        pending_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_d;
                    scr_q <= scr_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (trig) begin
                        pending_q <= 1'b1;
                    end
                    if (cnt_q == CW'(W-1)) begin
                        state_q     <= DONE;
                        bcd_out_q   <= scr_d;
                        busy_q      <= 1'b0;
                        bcd_valid_q <= ~(pending_q | trig);
                    end
                end
                DONE: begin
                    if (pending_q | trig) begin
                        pending_q   <= 1'b0;
                        bcd_valid_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= LOAD;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bcd_out   = bcd_out_q;
    assign bcd_valid = bcd_valid_q;
    assign busy      = busy_q;
    assign best_ms   = best_q;
    assign trials    = trials_q;
    assign new_best  = new_best_q;

endmodule

// File: tb/tb_reaction_stats.sv
// Self-checking bench for reaction_stats: directed scenarios plus randomized
// traffic compared against a queue-based statistics model.
module tb_reaction_stats;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear_stats;
    logic        result_valid;
    logic [19:0] result_ms;
    logic [1:0]  sel;
    logic [19:0] bcd_out;
    logic        bcd_valid;
    logic        busy;
    logic [19:0] best_ms;
    logic [7:0]  trials;
    logic        new_best;

    int n_checks = 0;
    int n_errors = 0;

    int unsigned m_last;
    int unsigned m_best;
    int unsigned m_trials;
    int unsigned m_hist[$];

    always #50 clk = ~clk;

    reaction_stats #(.W(20), .HIST(4), .MAX_MS(99999)) dut (
        .ADC_CLK_10  (clk),
        .reset       (reset),
        .clear_stats (clear_stats),
        .result_valid(result_valid),
        .result_ms   (result_ms),
        .sel         (sel),
        .bcd_out     (bcd_out),
        .bcd_valid   (bcd_valid),
        .busy        (busy),
        .best_ms     (best_ms),
        .trials      (trials),
        .new_best    (new_best)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        m_last   = 0;
        m_best   = 99999;
        m_trials = 0;
        m_hist.delete();
    endfunction

    function automatic logic model_accept(input int unsigned raw);
        int unsigned c;
        logic nb;
        c  = (raw > 99999) ? 99999 : raw;
        nb = (c < m_best);
        m_last = c;
        m_hist.push_back(c);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        if (m_trials < 255) m_trials++;
        if (nb) m_best = c;
        return nb;
    endfunction

    function automatic int unsigned model_avg();
        int unsigned s = 0;
        if (m_trials < 4) return m_last;
        foreach (m_hist[i]) s += m_hist[i];
        return s / 4;
    endfunction

    function automatic int unsigned model_value(input logic [1:0] s);
        case (s)
            2'd0:    return m_last;
            2'd1:    return m_best;
            2'd2:    return model_avg();
            default: return m_trials;
        endcase
    endfunction

    function automatic logic [19:0] to_bcd(input int unsigned v);
        logic [19:0] r = '0;
        int unsigned x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; clear_stats = 1'b0; result_valid = 1'b0; result_ms = '0; sel = 2'd0;
        tick(); tick();
        reset = 1'b0;
        model_reset();
        tick();
    endtask

    // One input cycle; new_best is compared the cycle after the strobe.
    task automatic step(input logic rv, input logic [19:0] val, input logic clr);
        logic exp_nb;
        result_valid = rv; result_ms = val; clear_stats = clr;
        tick();
        exp_nb = 1'b0;
        if (clr) model_reset();
        else if (rv) exp_nb = model_accept(val);
        check("new_best", new_best, exp_nb);
        result_valid = 1'b0; clear_stats = 1'b0;
    endtask

    task automatic set_sel(input logic [1:0] s);
        sel = s;
        tick();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (bcd_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) begin
            check({tag, "_timeout"}, bcd_valid, 1'b1);
        end else begin
            check({tag, "_bcd"}, bcd_out, to_bcd(model_value(sel)));
            check({tag, "_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        logic early;
        int unsigned r;
        logic [19:0] v;

        do_reset();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", bcd_valid, 1'b0);
        check("rst_bcd", bcd_out, 20'h0);
        check("rst_best", best_ms, 20'd99999);
        check("rst_trials", trials, 8'd0);
        check("rst_new_best", new_best, 1'b0);

        // Latency from a sel change to bcd_valid
        sel = 2'd1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 21) check("lat_early", bcd_valid, 1'b0);
            if (k == 22) begin
                check("lat_valid", bcd_valid, 1'b1);
                check("lat_busy", busy, 1'b0);
                check("lat_bcd", bcd_out, 20'h99999);
            end
        end

        // Best tracking, tie is not a new best
        do_reset();
        set_sel(2'd1);
        wait_valid("best0");
        step(1'b1, 20'd400, 1'b0); check("nb400", new_best, 1'b1); wait_valid("best1");
        step(1'b1, 20'd300, 1'b0); check("nb300", new_best, 1'b1); wait_valid("best2");
        step(1'b1, 20'd300, 1'b0); check("nb300tie", new_best, 1'b0); wait_valid("best3");
        step(1'b1, 20'd100, 1'b0); check("nb100", new_best, 1'b1); wait_valid("best4");
        check("best_ms", best_ms, 20'd100);
        check("best_bcd", bcd_out, 20'h00100);

        // Average: last before HIST results, truncated mean afterwards
        do_reset();
        set_sel(2'd2);
        wait_valid("avg0");
        step(1'b1, 20'd100, 1'b0); wait_valid("avg1");
        step(1'b1, 20'd200, 1'b0); wait_valid("avg2");
        step(1'b1, 20'd300, 1'b0); wait_valid("avg3");
        check("avg3_last", bcd_out, 20'h00300);
        step(1'b1, 20'd400, 1'b0); wait_valid("avg4");
        check("avg4_250", bcd_out, 20'h00250);
        step(1'b1, 20'd600, 1'b0); wait_valid("avg5");
        check("avg5_375", bcd_out, 20'h00375);

        // Clamp
        do_reset();
        step(1'b1, 20'd120000, 1'b0);
        wait_valid("clamp");
        check("clamp_bcd", bcd_out, 20'h99999);
        check("clamp_trials", trials, 8'd1);

        // Triggers while busy collapse into one rerun
        do_reset();
        sel = 2'd1;
        early = 1'b0;
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (k < 44 && bcd_valid) early = 1'b1;
            if (k == 5) sel = 2'd2;
            if (k == 10) begin result_valid = 1'b1; result_ms = 20'd500; end
            if (k == 11) begin result_valid = 1'b0; void'(model_accept(500)); end
        end
        check("rerun_no_early", early, 1'b0);
        check("rerun_valid", bcd_valid, 1'b1);
        check("rerun_bcd", bcd_out, 20'h00500);
        step(1'b1, 20'd50, 1'b1);
        wait_valid("clr");
        check("clr_trials", trials, 8'd0);
        check("clr_best", best_ms, 20'd99999);
        check("clr_bcd", bcd_out, 20'h00000);

        // Async reset mid-SHIFT, then trial-count saturation
        set_sel(2'd1);
        wait_valid("pre_abort");
        sel = 2'd0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", bcd_valid, 1'b0);
        check("abort_bcd", bcd_out, 20'h0);
        tick(); tick();
        reset = 1'b0;
        model_reset();
        tick();
        set_sel(2'd3);
        for (int i = 0; i < 256; i++) step(1'b1, 20'($urandom_range(100, 900)), 1'b0);
        wait_valid("sat");
        check("sat_trials", trials, 8'd255);
        check("sat_bcd", bcd_out, 20'h00255);

        // Randomized traffic
        do_reset();
        for (int it = 0; it < 150; it++) begin
            repeat ($urandom_range(1, 4)) begin
                r = $urandom_range(0, 19);
                if (r == 0) v = 20'(m_best);
                else if (r == 1) v = 20'($urandom_range(99990, 130000));
                else v = 20'($urandom_range(50, 2000));
                if (r < 14) step(1'b1, v, 1'b0);
                else if (r == 19) step(1'b1, v, 1'b1);
                else set_sel(2'($urandom_range(0, 3)));
                repeat ($urandom_range(0, 25)) tick();
            end
            wait_valid("rand");
            check("rand_best", best_ms, 20'(m_best));
            check("rand_trials", trials, 8'(m_trials));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
